// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
// Shared definitions for the memory-access stage: load/store type codes
// (sl_type), write-back source select codes, access-size decodes and the
// LSU state enum. Imported by the interface users, the top and the load
// alignment unit.
// Optional feature macro used by the files importing this package:
//   MEM_MISALIGN_TRAP_EN

package mem_stage_lsu_pkg;

   // sl_type layout: [3] store, [2] unsigned, [1:0] size
   localparam logic [3:0] SL_NONE = 4'b0000;
   localparam logic [3:0] SL_LB   = 4'b0001;
   localparam logic [3:0] SL_LH   = 4'b0010;
   localparam logic [3:0] SL_LW   = 4'b0011;
   localparam logic [3:0] SL_LBU  = 4'b0101;
   localparam logic [3:0] SL_LHU  = 4'b0110;
   localparam logic [3:0] SL_SB   = 4'b1001;
   localparam logic [3:0] SL_SH   = 4'b1010;
   localparam logic [3:0] SL_SW   = 4'b1011;

   localparam logic [1:0] SIZE_B = 2'b01;
   localparam logic [1:0] SIZE_H = 2'b10;
   localparam logic [1:0] SIZE_W = 2'b11;

   // Write-back source select; only the DRAM code matters in this stage
   localparam logic [1:0] WD_SEL_EX   = 2'b00;
   localparam logic [1:0] WD_SEL_DRAM = 2'b01;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } lsuState_t;

   // True for the five legal load encodings
   function automatic logic isLoadType(input logic [3:0] slType);
      return (slType == SL_LB) || (slType == SL_LH) || (slType == SL_LW) ||
             (slType == SL_LBU) || (slType == SL_LHU);
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if
// Data-memory request/ready bus between the memory stage (master) and the
// data memory (slave). One outstanding access; the master holds
// req/we/addr/be/wdata stable until the slave returns ready, and rdata is
// valid in the ready cycle.
//   req   master->slave  request valid
//   we    master->slave  write request
//   addr  master->slave  word address, bits [1:0] = 0
//   be    master->slave  byte enables
//   wdata master->slave  lane-replicated store data
//   ready slave->master  access complete
//   rdata slave->master  read word

interface mem_stage_lsu_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  ready, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output ready, rdata
   );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// mem_load_align
// Combinational load-data formatter. Shifts the read word right by the
// byte offset, selects byte/halfword/word by the size field of sl_type and
// zero- or sign-extends according to the unsigned bit.
//   rdata_i     read word from data memory
//   offset_i    byte offset within the word
//   sl_type_i   load/store type code
//   load_data_o extended 32-bit load value

module mem_load_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [3:0]  sl_type_i,
   output logic [31:0] load_data_o
);

   logic [31:0] shifted;

   // Bring the addressed byte/halfword down to bit 0, then extend it
   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      case (sl_type_i[1:0])
         SIZE_B:  load_data_o = sl_type_i[2] ? {24'b0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_H:  load_data_o = sl_type_i[2] ? {16'b0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
         default: load_data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Memory-access stage. Decodes the EX/MEM load/store type, runs a two-state
// request/ready handshake on the data-memory bus, stalls upstream while an
// access is in flight and registers the result into MEM/WB.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   *_mem_i                  EX/MEM register contents
//   dmem                     data-memory bus (master side)
//   stall_mem_o              hold EX/MEM and earlier stages
//   *_wb_o                   MEM/WB register contents
// Macro MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and are
// flagged on misalign_wb_o; without it they are aligned down and proceed.

module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_mem_i,
   input  logic [31:0] alu_result_mem_i,
   input  logic [31:0] wd_mem_i,
   input  logic [31:0] rD2_mem_i,
   input  logic        instr_valid_mem_i,
   input  logic        dram_we_mem_i,
   input  logic        rf_we_mem_i,
   input  logic [1:0]  wd_sel_mem_i,
   input  logic [4:0]  wr_mem_i,
   input  logic [3:0]  sl_type_mem_i,
   mem_stage_lsu_if.master dmem,
   output logic        stall_mem_o,
   output logic [31:0] pc_wb_o,
   output logic [31:0] wd_wb_o,
   output logic        instr_valid_wb_o,
   output logic        rf_we_wb_o,
   output logic [4:0]  wr_wb_o,
   output logic        misalign_wb_o
);

   lsuState_t   state_q, state_d;
   logic [1:0]  size, addrLow, effOffset;
   logic        isStore, isLoad, isAccess, doAccess, trapNow;
   logic        dmemWe_q;
   logic [31:0] dmemAddr_q, dmemWdata_q, beWdataUnused;
   logic [3:0]  dmemBe_q, beD;
   logic [31:0] wdataD, loadData, wbData;
   logic [31:0] pcWb_q, wdWb_q;
   logic [4:0]  wrWb_q;
   logic        validWb_q, rfWeWb_q, misalignWb_q;

   assign size     = sl_type_mem_i[1:0];
   assign addrLow  = alu_result_mem_i[1:0];
   assign isStore  = instr_valid_mem_i & dram_we_mem_i & (size != 2'b00);
   assign isLoad   = instr_valid_mem_i & ~dram_we_mem_i & isLoadType(sl_type_mem_i);
   assign isAccess = isStore | isLoad;
   assign beWdataUnused = 32'b0;

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned;
   // Misaligned accesses never reach the bus; they become a one-cycle trap
   assign misaligned = isAccess & (((size == SIZE_H) & addrLow[0]) |
                                   ((size == SIZE_W) & (addrLow != 2'b00)));
   assign doAccess  = isAccess & ~misaligned;
   assign trapNow   = misaligned;
   assign effOffset = addrLow;
`else
   assign doAccess = isAccess;
   assign trapNow  = 1'b0;
   // Without trapping, halfword/word offsets are forced down to alignment
   always_comb begin
      effOffset = addrLow;
      if (size == SIZE_H) effOffset[0] = 1'b0;
      if (size == SIZE_W) effOffset = 2'b00;
   end
`endif

   // Byte enables and lane-replicated store data; loads read the full word
   always_comb begin
      beD    = 4'b1111;
      wdataD = rD2_mem_i;
      if (isStore) begin
         case (size)
            SIZE_B: begin
               beD    = 4'b0001 << effOffset;
               wdataD = {4{rD2_mem_i[7:0]}};
            end
            SIZE_H: begin
               beD    = 4'b0011 << {effOffset[1], 1'b0};
               wdataD = {2{rD2_mem_i[15:0]}};
            end
            default: ;
         endcase
      end
   end

   mem_load_align u_load_align (
      .rdata_i     (dmem.rdata),
      .offset_i    (effOffset),
      .sl_type_i   (sl_type_mem_i),
      .load_data_o (loadData)
   );

   assign wbData = ((wd_sel_mem_i == WD_SEL_DRAM) && isLoad) ? loadData : wd_mem_i;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: IDLE launches an access, BUSY waits for ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (doAccess)   state_d = ST_BUSY;
         ST_BUSY: if (dmem.ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: request follows the registered state; stall releases in
   // the ready cycle so the pipeline advances as the result is captured
   always_comb begin
      dmem.req    = (state_q == ST_BUSY);
      stall_mem_o = ~rst & doAccess & ~((state_q == ST_BUSY) & dmem.ready);
   end

   // Bus attributes are captured once on launch and held through BUSY
   always_ff @(posedge clk) begin
      if (rst) begin
         dmemWe_q    <= 1'b0;
         dmemAddr_q  <= 32'b0;
         dmemBe_q    <= 4'b0;
         dmemWdata_q <= 32'b0;
      end else if ((state_q == ST_IDLE) && doAccess) begin
         dmemWe_q    <= isStore;
         dmemAddr_q  <= {alu_result_mem_i[31:2], 2'b00};
         dmemBe_q    <= beD;
         dmemWdata_q <= wdataD | beWdataUnused;
      end
   end

   assign dmem.we    = dmemWe_q;
   assign dmem.addr  = dmemAddr_q;
   assign dmem.be    = dmemBe_q;
   assign dmem.wdata = dmemWdata_q;

   // MEM/WB register; a stalled cycle inserts a bubble, a trap is valid
   // but suppresses the register-file write
   always_ff @(posedge clk) begin
      if (rst) begin
         pcWb_q       <= 32'b0;
         wdWb_q       <= 32'b0;
         wrWb_q       <= 5'b0;
         validWb_q    <= 1'b0;
         rfWeWb_q     <= 1'b0;
         misalignWb_q <= 1'b0;
      end else begin
         pcWb_q <= pc_mem_i;
         wdWb_q <= wbData;
         wrWb_q <= wr_mem_i;
         if (stall_mem_o) begin
            validWb_q    <= 1'b0;
            rfWeWb_q     <= 1'b0;
            misalignWb_q <= 1'b0;
         end else if (trapNow) begin
            validWb_q    <= 1'b1;
            rfWeWb_q     <= 1'b0;
            misalignWb_q <= 1'b1;
         end else begin
            validWb_q    <= instr_valid_mem_i;
            rfWeWb_q     <= rf_we_mem_i;
            misalignWb_q <= 1'b0;
         end
      end
   end

   assign pc_wb_o          = pcWb_q;
   assign wd_wb_o          = wdWb_q;
   assign wr_wb_o          = wrWb_q;
   assign instr_valid_wb_o = validWb_q;
   assign rf_we_wb_o       = rfWeWb_q;
   assign misalign_wb_o    = misalignWb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
// Self-checking bench for mem_stage_lsu: directed cases followed by random
// instructions, each compared with a reference model computed from the
// load/store rules in byte-offset arithmetic. The bench plays the data
// memory, choosing the latency of every access.
// Honours MEM_MISALIGN_TRAP_EN the same way the design does.

module tb_mem_stage_lsu;
   import mem_stage_lsu_pkg::*;

   typedef struct {
      logic        valid;
      logic [3:0]  slType;
      logic        dramWe;
      logic [1:0]  wdSel;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rD2;
      logic [4:0]  wr;
      logic        rfWe;
   } instr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcMem, aluResultMem, wdMem, rD2Mem;
   logic        instrValidMem, dramWeMem, rfWeMem;
   logic [1:0]  wdSelMem;
   logic [4:0]  wrMem;
   logic [3:0]  slTypeMem;
   logic        stallMem;
   logic [31:0] pcWb, wdWb;
   logic        instrValidWb, rfWeWb, misalignWb;
   logic [4:0]  wrWb;

   int assertCount = 0;
   int failCount   = 0;

   mem_stage_lsu_if dmemIf ();

   mem_stage_lsu dut (
      .clk               (clk),
      .rst               (rst),
      .pc_mem_i          (pcMem),
      .alu_result_mem_i  (aluResultMem),
      .wd_mem_i          (wdMem),
      .rD2_mem_i         (rD2Mem),
      .instr_valid_mem_i (instrValidMem),
      .dram_we_mem_i     (dramWeMem),
      .rf_we_mem_i       (rfWeMem),
      .wd_sel_mem_i      (wdSelMem),
      .wr_mem_i          (wrMem),
      .sl_type_mem_i     (slTypeMem),
      .dmem              (dmemIf),
      .stall_mem_o       (stallMem),
      .pc_wb_o           (pcWb),
      .wd_wb_o           (wdWb),
      .instr_valid_wb_o  (instrValidWb),
      .rf_we_wb_o        (rfWeWb),
      .wr_wb_o           (wrWb),
      .misalign_wb_o     (misalignWb)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input instr_t ins);
      instrValidMem = ins.valid;
      slTypeMem     = ins.slType;
      dramWeMem     = ins.dramWe;
      wdSelMem      = ins.wdSel;
      pcMem         = ins.pc;
      aluResultMem  = ins.addr;
      wdMem         = ins.wd;
      rD2Mem        = ins.rD2;
      wrMem         = ins.wr;
      rfWeMem       = ins.rfWe;
   endtask

   task automatic checkBubble(input string tag);
      checkOutput({tag, ".bubbleValid"}, 32'(instrValidWb), 32'd0);
      checkOutput({tag, ".bubbleRfWe"}, 32'(rfWeWb), 32'd0);
      checkOutput({tag, ".bubbleMis"}, 32'(misalignWb), 32'd0);
   endtask

   // Runs one instruction from posedge+1 to posedge+1; latency is the
   // number of BUSY cycles up to and including the ready cycle
   task automatic runInstr(input string tag, input instr_t ins, input int latency,
                           input logic [31:0] rdata);
      logic        isLoad, isStore, misal, trap, access;
      int          nBytes, off;
      logic [31:0] eff, expAddr, expWdata, shifted, loadVal, expWd;
      logic [3:0]  expBe;

      isLoad  = ins.valid && !ins.dramWe && (ins.slType inside {SL_LB, SL_LH, SL_LW, SL_LBU, SL_LHU});
      isStore = ins.valid && ins.dramWe && (ins.slType[1:0] != 2'b00);
      case (ins.slType[1:0])
         2'b01:   nBytes = 1;
         2'b10:   nBytes = 2;
         2'b11:   nBytes = 4;
         default: nBytes = 1;
      endcase
      misal = (isLoad || isStore) && ((ins.addr % nBytes) != 0);
`ifdef MEM_MISALIGN_TRAP_EN
      trap = misal;
      eff  = ins.addr;
`else
      trap = 1'b0;
      eff  = ins.addr - (ins.addr % nBytes);
`endif
      access  = (isLoad || isStore) && !trap;
      off     = int'(eff % 4);
      expAddr = eff - 32'(off);
      if (isStore && nBytes == 1)      expBe = 4'(32'd1 << off);
      else if (isStore && nBytes == 2) expBe = 4'(32'd3 << off);
      else                             expBe = 4'b1111;
      if (isStore && nBytes == 1)      expWdata = 32'(ins.rD2[7:0]) * 32'h01010101;
      else if (isStore && nBytes == 2) expWdata = 32'(ins.rD2[15:0]) * 32'h00010001;
      else                             expWdata = ins.rD2;
      shifted = rdata >> (8 * off);
      if (nBytes == 1) begin
         loadVal = shifted & 32'hFF;
         if (!ins.slType[2] && loadVal >= 32'd128) loadVal = loadVal - 32'd256;
      end else if (nBytes == 2) begin
         loadVal = shifted & 32'hFFFF;
         if (!ins.slType[2] && loadVal >= 32'd32768) loadVal = loadVal - 32'd65536;
      end else begin
         loadVal = shifted;
      end
      expWd = (isLoad && ins.wdSel == WD_SEL_DRAM) ? loadVal : ins.wd;

      applyStimulus(ins);
      if (!access) begin
         @(negedge clk);
         checkOutput({tag, ".stall"}, 32'(stallMem), 32'd0);
         checkOutput({tag, ".reqIdle"}, 32'(dmemIf.req), 32'd0);
         @(posedge clk); #1;
         checkOutput({tag, ".valid"}, 32'(instrValidWb), 32'(ins.valid || trap));
         checkOutput({tag, ".rfWe"}, 32'(rfWeWb), 32'(trap ? 1'b0 : ins.rfWe));
         checkOutput({tag, ".mis"}, 32'(misalignWb), 32'(trap));
         checkOutput({tag, ".pc"}, pcWb, ins.pc);
         checkOutput({tag, ".wr"}, 32'(wrWb), 32'(ins.wr));
         if (!trap) checkOutput({tag, ".wd"}, wdWb, expWd);
      end else begin
         @(negedge clk);
         checkOutput({tag, ".stallLaunch"}, 32'(stallMem), 32'd1);
         checkOutput({tag, ".reqLaunch"}, 32'(dmemIf.req), 32'd0);
         @(posedge clk); #1;
         checkBubble({tag, ".launch"});
         for (int j = 1; j <= latency; j++) begin
            dmemIf.ready = (j == latency);
            dmemIf.rdata = (j == latency) ? rdata : $urandom;
            @(negedge clk);
            checkOutput({tag, ".req"}, 32'(dmemIf.req), 32'd1);
            checkOutput({tag, ".addr"}, dmemIf.addr, expAddr);
            checkOutput({tag, ".be"}, 32'(dmemIf.be), 32'(expBe));
            checkOutput({tag, ".we"}, 32'(dmemIf.we), 32'(isStore));
            if (isStore) checkOutput({tag, ".wdata"}, dmemIf.wdata, expWdata);
            checkOutput({tag, ".stallBusy"}, 32'(stallMem), 32'(j != latency));
            @(posedge clk); #1;
            if (j != latency) checkBubble({tag, ".wait"});
         end
         dmemIf.ready = 1'b0;
         checkOutput({tag, ".valid"}, 32'(instrValidWb), 32'd1);
         checkOutput({tag, ".rfWe"}, 32'(rfWeWb), 32'(ins.rfWe));
         checkOutput({tag, ".mis"}, 32'(misalignWb), 32'd0);
         checkOutput({tag, ".pc"}, pcWb, ins.pc);
         checkOutput({tag, ".wr"}, 32'(wrWb), 32'(ins.wr));
         checkOutput({tag, ".wd"}, wdWb, expWd);
      end
   endtask

   function automatic instr_t mkInstr(input logic [3:0] slType, input logic [31:0] addr,
                                      input logic [31:0] rD2, input logic [4:0] wr);
      instr_t ins;
      ins.valid  = 1'b1;
      ins.slType = slType;
      ins.dramWe = slType[3];
      ins.wdSel  = (slType == SL_NONE || slType[3]) ? WD_SEL_EX : WD_SEL_DRAM;
      ins.pc     = 32'h0000_1000 + 32'(wr) * 4;
      ins.addr   = addr;
      ins.wd     = 32'hDEAD_0000 | 32'(wr);
      ins.rD2    = rD2;
      ins.wr     = wr;
      ins.rfWe   = !slType[3];
      return ins;
   endfunction

   // Directed scenarios first, then randomized instructions
   initial begin
      instr_t ins;
      logic [3:0] codes [9];
      codes = '{SL_NONE, SL_LB, SL_LH, SL_LW, SL_LBU, SL_LHU, SL_SB, SL_SH, SL_SW};

      rst = 1'b1;
      dmemIf.ready = 1'b0;
      dmemIf.rdata = 32'b0;
      applyStimulus(mkInstr(SL_NONE, 32'h0, 32'h0, 5'd0));
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.req", 32'(dmemIf.req), 32'd0);
      checkOutput("reset.stall", 32'(stallMem), 32'd0);
      checkOutput("reset.valid", 32'(instrValidWb), 32'd0);
      checkOutput("reset.rfWe", 32'(rfWeWb), 32'd0);
      checkOutput("reset.pc", pcWb, 32'd0);
      checkOutput("reset.wd", wdWb, 32'd0);
      checkOutput("reset.addr", dmemIf.addr, 32'd0);
      checkOutput("reset.be", 32'(dmemIf.be), 32'd0);
      rst = 1'b0;

      ins = mkInstr(SL_NONE, 32'h0, 32'h0, 5'd5);
      ins.wd = 32'h1234;
      runInstr("add", ins, 1, 32'h0);

      runInstr("sb103", mkInstr(SL_SB, 32'h103, 32'h0000_00AB, 5'd0), 3, 32'h0);
      runInstr("lb102", mkInstr(SL_LB, 32'h102, 32'h0, 5'd6), 2, 32'h0080_FF00);
      runInstr("lbu102", mkInstr(SL_LBU, 32'h102, 32'h0, 5'd7), 1, 32'h0080_FF00);
      runInstr("lhu102", mkInstr(SL_LHU, 32'h102, 32'h0, 5'd8), 2, 32'h0080_FF00);
      runInstr("lw200", mkInstr(SL_LW, 32'h200, 32'h0, 5'd9), 1, 32'hCAFE_BABE);
      runInstr("lw202", mkInstr(SL_LW, 32'h202, 32'h0, 5'd10), 2, 32'h1357_9BDF);
      runInstr("sh106", mkInstr(SL_SH, 32'h106, 32'h1234_BEEF, 5'd0), 2, 32'h0);
      runInstr("lh_neg", mkInstr(SL_LH, 32'h300, 32'h0, 5'd11), 1, 32'h0000_8001);

      // Ready asserted while idle must be ignored
      dmemIf.ready = 1'b1;
      runInstr("readyIdle", mkInstr(SL_NONE, 32'h0, 32'h0, 5'd12), 1, 32'h0);
      dmemIf.ready = 1'b0;

      // Reset while an access is outstanding abandons it
      applyStimulus(mkInstr(SL_LW, 32'h400, 32'h0, 5'd13));
      @(posedge clk); #1;
      checkOutput("rstBusy.reqBefore", 32'(dmemIf.req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rstBusy.stallInRst", 32'(stallMem), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(mkInstr(SL_NONE, 32'h0, 32'h0, 5'd0));
      checkOutput("rstBusy.req", 32'(dmemIf.req), 32'd0);
      checkOutput("rstBusy.stall", 32'(stallMem), 32'd0);
      checkOutput("rstBusy.valid", 32'(instrValidWb), 32'd0);
      checkOutput("rstBusy.rfWe", 32'(rfWeWb), 32'd0);
      checkOutput("rstBusy.mis", 32'(misalignWb), 32'd0);
      checkOutput("rstBusy.pc", pcWb, 32'd0);
      checkOutput("rstBusy.wd", wdWb, 32'd0);
      checkOutput("rstBusy.wr", 32'(wrWb), 32'd0);

      for (int i = 0; i < 40; i++) begin
         ins        = mkInstr(codes[$urandom_range(0, 8)], $urandom, $urandom, 5'($urandom));
         ins.valid  = ($urandom_range(0, 7) != 0);
         ins.rfWe   = 1'($urandom);
         ins.wd     = $urandom;
         ins.pc     = $urandom;
         if ($urandom_range(0, 3) == 0) ins.wdSel = 2'($urandom);
         runInstr($sformatf("rand%0d", i), ins, $urandom_range(1, 4), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-access stage of the five-stage pipeline, between the EX/MEM pipeline register and the register-file write-back. It decodes the registered load/store type. It drives a single-outstanding, variable-latency data-memory request/ready handshake with byte enables. It aligns and sign/zero-extends load data, stalls upstream while an access is in flight, and registers the result into the MEM/WB boundary.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- pc_mem_i, alu_result_mem_i, wd_mem_i, rD2_mem_i  in  32 each  PC, effective address, pre-muxed write-back data, store data.
- instr_valid_mem_i, dram_we_mem_i, rf_we_mem_i  in  1 each  valid, store enable, RF write enable.
- wd_sel_mem_i  in  2  write-back source; WD_SEL_DRAM (2'b01) selects load data.
- wr_mem_i  in  5  destination register.
- sl_type_mem_i  in  4  [3] store, [2] unsigned, [1:0] size 01=B 10=H 11=W, 0000=none.
- dmem_req_o  out  1  request valid, held until dmem_ready_i.
- dmem_we_o  out  1  write request.
- dmem_addr_o  out  32  word address, bits [1:0]=0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_ready_i  in  1  access complete; read data valid this cycle.
- dmem_rdata_i  in  32  read word.
- stall_mem_o  out  1  hold EX/MEM and earlier stages.
- pc_wb_o  out  32  registered PC.
- wd_wb_o  out  32  registered write-back data.
- instr_valid_wb_o, rf_we_wb_o  out  1 each  registered valid and RF write enable.
- wr_wb_o  out  5  registered destination register.
- misalign_wb_o  out  1  registered misaligned-access flag.

## Operation
- An access requires instr_valid_mem_i=1. A store is dram_we_mem_i=1, with width from sl_type_mem_i[1:0]. A load is dram_we_mem_i=0 with sl_type in {LB,LH,LW,LBU,LHU}. Anything else is a non-access.
- The FSM has two states.
  - IDLE: on an aligned access, latch addr/be/wdata/we and go to BUSY. Otherwise stay in IDLE.
  - BUSY: dmem_req_o=1. On dmem_ready_i, return to IDLE.
- stall_mem_o is combinational. It is 1 when an access is present and not (BUSY and dmem_ready_i).
- While stalled, the WB register loads a bubble: instr_valid_wb_o=0, rf_we_wb_o=0, misalign_wb_o=0.
- Byte enables and store data:
  - SB: be=4'b0001<<a[1:0], wdata={4{rD2[7:0]}}.
  - SH: be=4'b0011<<{a[1],0}, wdata={2{rD2[15:0]}}.
  - SW: be=4'b1111, wdata=rD2.
  - Loads: be=4'b1111.
- Load data: shift dmem_rdata_i right by 8*a[1:0], take a byte or halfword, then zero-extend if sl_type[2]=1, else sign-extend.
- WB data: if wd_sel_mem_i=WD_SEL_DRAM and the instruction is a load, use load data. Otherwise use wd_mem_i.
- Misaligned: H with a[0]=1, or W with a[1:0]≠0. Behaviour is set under Configuration.

## Timing
- Non-access: 1-cycle latency to the WB outputs, no stall.
- Access: detected in IDLE in cycle N; request in cycle N+1. If ready arrives in cycle N+k (k≥1), WB outputs update at the end of cycle N+k. Stall is high for cycles N..N+k-1.
- The dmem_* outputs are registered. addr/be/wdata/we are stable while dmem_req_o=1. dmem_req_o drops the cycle after ready.
- At most one access is outstanding. Back-to-back accesses insert one IDLE cycle.
- Reset values: state IDLE; all outputs 0, including dmem_req_o, stall_mem_o (rst forces 0), and all *_wb_o.
- Reset during BUSY: the next cycle is IDLE with dmem_req_o=0. Memory must tolerate an abandoned request.
- dmem_ready_i while IDLE is ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access issues no bus request and no stall.
  - WB shows instr_valid_wb_o=1, rf_we_wb_o=0, misalign_wb_o=1 for one cycle.
- MEM_MISALIGN_TRAP_EN undefined:
  - The address is aligned down (H: a[0]←0; W: a[1:0]←0) and the access proceeds.
  - misalign_wb_o is tied to 0.

## Structure
- Shared package holds:
  - SL_* sl_type codes: NONE=0000, LB=0001, LH=0010, LW=0011, LBU=0101, LHU=0110, SB=1001, SH=1010, SW=1011.
  - WD_SEL_* codes.
  - FSM state enum.
- Sub-module mem_load_align: combinational rdata/offset/sl_type → 32-bit extended load value.

## Test plan
- ADD (wd_sel=00, wd=0x1234, wr=5): WB outputs one cycle later with rf_we=1; stall never asserted.
- SB at 0x103, rD2=0x000000AB: be=1000, wdata=0xABABABAB, addr=0x100. Ready after 3 cycles gives stall for 3 cycles and bubbles in WB.
- LB at 0x102, rdata=0x0080FF00: wd_wb=0xFFFFFF80. LBU at the same address: 0x00000080. LHU at 0x102: 0x00000080.
- LW at 0x200 with ready in the first BUSY cycle: exactly one stall cycle, wd_wb=rdata.
- LW at 0x202: with the macro, no req and misalign_wb_o=1, rf_we_wb_o=0. Without the macro, addr=0x200 and a normal load.
- rst asserted mid-BUSY: next cycle dmem_req_o=0, stall_mem_o=0, all WB outputs 0.
